// File: rtl/rf_level_ctrl.sv
// Interrupt level sequencer: drains the pipe, pushes the running bank, switches to the irq bank, marks ra.
// Switch latency DrainCycles+2 stalled cycles after acceptance; mret pops in one cycle with no stall.
module rf_level_ctrl #(
  parameter int NumLevels   = 8,
  parameter int LevelsWidth = $clog2(NumLevels),
  parameter int DrainCycles = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   irq_valid,
  input  logic [LevelsWidth-1:0] irq_prio,
  input  logic                   mret,
  output logic [LevelsWidth-1:0] level,
  output logic                   write_ra_en,
  output logic                   pipe_stall,
  output logic                   irq_ack,
  output logic [LevelsWidth-1:0] depth,
  output logic                   mret_err
);

  localparam int CntWidth = (DrainCycles > 1) ? $clog2(DrainCycles) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, SWITCH, MARK} state_e;

  state_e                 state_q, state_d;
  logic [LevelsWidth-1:0] level_q, level_d;
  logic [LevelsWidth-1:0] depth_q, depth_d;
  logic [LevelsWidth-1:0] prio_q, prio_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic                   mret_err_q, mret_err_d;
  logic [LevelsWidth-1:0] stack_q [NumLevels];
  logic [LevelsWidth-1:0] stack_d [NumLevels];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      level_q    <= '0;
      depth_q    <= '0;
      prio_q     <= '0;
      cnt_q      <= '0;
      mret_err_q <= 1'b0;
      for (int i = 0; i < NumLevels; i++) stack_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      depth_q    <= depth_d;
      prio_q     <= prio_d;
      cnt_q      <= cnt_d;
      mret_err_q <= mret_err_d;
      for (int i = 0; i < NumLevels; i++) stack_q[i] <= stack_d[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    depth_d    = depth_q;
    prio_d     = prio_q;
    cnt_d      = cnt_q;
    mret_err_d = 1'b0;
    for (int i = 0; i < NumLevels; i++) stack_d[i] = stack_q[i];
    case (state_q)
      RUN: begin
        // mret wins; a concurrent irq is re-judged next cycle against the popped level
        if (mret) begin
          if (depth_q != '0) begin
            level_d = stack_q[depth_q - LevelsWidth'(1)];
            depth_d = depth_q - LevelsWidth'(1);
          end else begin
            mret_err_d = 1'b1;
          end
        end else if (irq_valid && (irq_prio > level_q) &&
                     (depth_q < LevelsWidth'(NumLevels - 1))) begin
          prio_d  = irq_prio;
          cnt_d   = CntWidth'(DrainCycles - 1);
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = SWITCH;
        else             cnt_d   = cnt_q - CntWidth'(1);
      end
      SWITCH: begin
        stack_d[depth_q] = level_q;
        depth_d          = depth_q + LevelsWidth'(1);
        level_d          = prio_q;
        state_d          = MARK;
      end
      MARK:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pipe_stall  = (state_q != RUN);
    irq_ack     = (state_q == SWITCH);
    write_ra_en = (state_q == MARK);
    level       = level_q;
    depth       = depth_q;
    mret_err    = mret_err_q;
  end

endmodule

// File: tb/tb_rf_level_ctrl.sv
// Directed bench for rf_level_ctrl: 8-level instance for the main sequences, 4-level instance for the full stack.
module tb_rf_level_ctrl;

  logic       clk;
  logic       reset;
  logic       irq_valid;
  logic [2:0] irq_prio;
  logic       mret;
  logic [2:0] level;
  logic       write_ra_en;
  logic       pipe_stall;
  logic       irq_ack;
  logic [2:0] depth;
  logic       mret_err;

  logic       b_irq_valid;
  logic [1:0] b_irq_prio;
  logic       b_mret;
  logic [1:0] b_level;
  logic       b_write_ra_en;
  logic       b_pipe_stall;
  logic       b_irq_ack;
  logic [1:0] b_depth;
  logic       b_mret_err;

  int checks = 0;
  int errors = 0;

  rf_level_ctrl #(.NumLevels(8), .DrainCycles(3)) u_dut (
    .clk(clk), .reset(reset), .irq_valid(irq_valid), .irq_prio(irq_prio), .mret(mret),
    .level(level), .write_ra_en(write_ra_en), .pipe_stall(pipe_stall),
    .irq_ack(irq_ack), .depth(depth), .mret_err(mret_err)
  );

  rf_level_ctrl #(.NumLevels(4), .DrainCycles(3)) u_dut4 (
    .clk(clk), .reset(reset), .irq_valid(b_irq_valid), .irq_prio(b_irq_prio), .mret(b_mret),
    .level(b_level), .write_ra_en(b_write_ra_en), .pipe_stall(b_pipe_stall),
    .irq_ack(b_irq_ack), .depth(b_depth), .mret_err(b_mret_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Request prio p from the current cycle; expects old_lvl before the switch and new_depth after it.
  task automatic do_irq(input logic [2:0] p, input logic [2:0] old_lvl, input logic [2:0] new_depth);
    irq_valid = 1'b1;
    irq_prio  = p;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("irq%0d_stall_c%0d", p, k), 8'(pipe_stall), 8'(1));
      chk($sformatf("irq%0d_ack_c%0d", p, k), 8'(irq_ack), 8'(k == 4));
      chk($sformatf("irq%0d_wra_c%0d", p, k), 8'(write_ra_en), 8'(k == 5));
      chk($sformatf("irq%0d_lvl_c%0d", p, k), 8'(level), (k == 5) ? 8'(p) : 8'(old_lvl));
      if (k == 4) irq_valid = 1'b0;
    end
    tick();
    chk($sformatf("irq%0d_stall_end", p), 8'(pipe_stall), 8'(0));
    chk($sformatf("irq%0d_lvl_end", p), 8'(level), 8'(p));
    chk($sformatf("irq%0d_depth_end", p), 8'(depth), 8'(new_depth));
  endtask

  initial begin
    reset = 1'b0; irq_valid = 1'b0; irq_prio = '0; mret = 1'b0;
    b_irq_valid = 1'b0; b_irq_prio = '0; b_mret = 1'b0;
    tick(); tick();
    chk("rst_level", 8'(level), 8'(0));
    chk("rst_depth", 8'(depth), 8'(0));
    chk("rst_stall", 8'(pipe_stall), 8'(0));
    chk("rst_ack", 8'(irq_ack), 8'(0));
    chk("rst_wra", 8'(write_ra_en), 8'(0));
    chk("rst_err", 8'(mret_err), 8'(0));
    reset = 1'b1;
    tick();
    chk("idle_stall", 8'(pipe_stall), 8'(0));

    // reset in the middle of a drain aborts the switch
    irq_valid = 1'b1; irq_prio = 3'd3;
    tick();
    chk("drain_stall", 8'(pipe_stall), 8'(1));
    tick();
    reset = 1'b0;
    #1;
    chk("abort_stall", 8'(pipe_stall), 8'(0));
    chk("abort_ack", 8'(irq_ack), 8'(0));
    chk("abort_level", 8'(level), 8'(0));
    chk("abort_depth", 8'(depth), 8'(0));
    irq_valid = 1'b0;
    tick(); tick();
    chk("abort_ack_later", 8'(irq_ack), 8'(0));
    reset = 1'b1;
    tick();

    do_irq(3'd3, 3'd0, 3'd1);
    do_irq(3'd5, 3'd3, 3'd2);

    // equal or lower priority is ignored silently
    irq_valid = 1'b1; irq_prio = 3'd5;
    tick();
    chk("eq_stall", 8'(pipe_stall), 8'(0));
    irq_prio = 3'd2;
    tick();
    chk("lo_stall", 8'(pipe_stall), 8'(0));
    chk("lo_ack", 8'(irq_ack), 8'(0));
    chk("lo_level", 8'(level), 8'(5));
    chk("lo_err", 8'(mret_err), 8'(0));
    irq_valid = 1'b0;

    mret = 1'b1;
    tick();
    chk("pop1_level", 8'(level), 8'(3));
    chk("pop1_depth", 8'(depth), 8'(1));
    chk("pop1_stall", 8'(pipe_stall), 8'(0));
    tick();
    chk("pop2_level", 8'(level), 8'(0));
    chk("pop2_depth", 8'(depth), 8'(0));
    chk("pop2_err", 8'(mret_err), 8'(0));
    tick();
    mret = 1'b0;
    chk("under_err", 8'(mret_err), 8'(1));
    chk("under_level", 8'(level), 8'(0));
    chk("under_depth", 8'(depth), 8'(0));
    tick();
    chk("under_err_clr", 8'(mret_err), 8'(0));

    // mret and irq together: pop first, accept next cycle
    do_irq(3'd3, 3'd0, 3'd1);
    mret = 1'b1; irq_valid = 1'b1; irq_prio = 3'd4;
    tick();
    mret = 1'b0;
    chk("same_level", 8'(level), 8'(0));
    chk("same_depth", 8'(depth), 8'(0));
    chk("same_stall", 8'(pipe_stall), 8'(0));
    do_irq(3'd4, 3'd0, 3'd1);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    chk("back0_level", 8'(level), 8'(0));

    for (int p = 1; p <= 7; p++) do_irq(3'(p), 3'(p - 1), 3'(p));
    irq_valid = 1'b1; irq_prio = 3'd7;
    tick(); tick();
    chk("full_stall", 8'(pipe_stall), 8'(0));
    chk("full_depth", 8'(depth), 8'(7));
    irq_valid = 1'b0;
    for (int p = 6; p >= 0; p--) begin
      mret = 1'b1;
      tick();
      chk($sformatf("unwind_level%0d", p), 8'(level), 8'(p));
      chk($sformatf("unwind_depth%0d", p), 8'(depth), 8'(p));
    end
    mret = 1'b0;
    tick();

    // 4-level instance fills to depth 3
    for (int p = 1; p <= 3; p++) begin
      b_irq_valid = 1'b1; b_irq_prio = 2'(p);
      for (int k = 1; k <= 5; k++) begin
        tick();
        chk($sformatf("b_irq%0d_ack_c%0d", p, k), 8'(b_irq_ack), 8'(k == 4));
        if (k == 4) b_irq_valid = 1'b0;
      end
      tick();
      chk($sformatf("b_lvl%0d", p), 8'(b_level), 8'(p));
      chk($sformatf("b_depth%0d", p), 8'(b_depth), 8'(p));
    end
    b_irq_valid = 1'b1; b_irq_prio = 2'd3;
    tick(); tick();
    chk("b_full_stall", 8'(b_pipe_stall), 8'(0));
    chk("b_full_ack", 8'(b_irq_ack), 8'(0));
    chk("b_full_depth", 8'(b_depth), 8'(3));
    b_irq_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_level_ctrl.md
Name: rf_level_ctrl

Overview:
- Interrupt level sequencer for the banked register-file stack; owns the current register bank `level`.
- On preemption it stalls and drains the pipeline, saves the running level on an internal level stack, switches the bank, then pulses `write_ra_en` so the file writes the return marker into ra.
- On return from interrupt it pops the saved level.
- Sits between the interrupt controller / decode stage and the register file stack.

Parameters:
- NumLevels, 8, number of register banks; level 0 is thread mode. Must be a power of two, ≥2.
- LevelsWidth, $clog2(NumLevels), width of level values (derived).
- DrainCycles, 3, stall cycles spent draining in-flight instructions before a bank switch; ≥1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- irq_valid  in  1  pending interrupt request; held until irq_ack.
- irq_prio  in  LevelsWidth  priority of the pending interrupt; 0 never preempts.
- mret  in  1  one-cycle pulse, return-from-interrupt retired.
- level  out  LevelsWidth  active bank; drives the register file `level`.
- write_ra_en  out  1  one-cycle pulse, drives the register file `writeRaEn`.
- pipe_stall  out  1  freezes fetch/decode while a switch is in progress.
- irq_ack  out  1  one-cycle pulse, request accepted and bank switched.
- depth  out  LevelsWidth  number of saved levels on the stack.
- mret_err  out  1  one-cycle pulse, mret with an empty stack.

Behaviour:
- Reset (reset=0, async): state RUN; level=0, depth=0, cnt=0; all pulse outputs 0; pipe_stall=0; stack contents cleared. Reset asserted in any state aborts the switch: no push, no ack.
- RUN:
  - pipe_stall=0.
  - If mret=1 and depth>0: level<=stack[depth-1]; depth<=depth-1; stay in RUN. Pop is single-cycle and no stall is raised.
  - If mret=1 and depth=0: mret_err pulses next cycle; level is unchanged.
  - Else if irq_valid=1, irq_prio>level (unsigned) and depth<NumLevels-1: latch prio_q<=irq_prio; cnt<=DrainCycles-1; go to DRAIN.
  - mret has priority over irq_valid in the same cycle; the irq is re-evaluated the next cycle against the popped level.
  - irq_prio ≤ level, or a full stack: request ignored, no ack, and no error raised.
- DRAIN:
  - pipe_stall=1. Decrement cnt each cycle; when cnt=0, go to SWITCH.
  - irq_valid or irq_prio changing here is ignored; prio_q is used.
  - mret during DRAIN is a protocol violation; ignore it and hold depth.
  - Time in DRAIN is exactly DrainCycles cycles.
- SWITCH:
  - pipe_stall=1.
  - stack[depth]<=level; depth<=depth+1; level<=prio_q; irq_ack=1 this cycle (combinational on state).
  - Go to MARK.
- MARK:
  - pipe_stall=1; write_ra_en=1 (level already equals the new bank); go to RUN.
- Latency: irq accepted in RUN at cycle t. pipe_stall is high on cycles t+1 through t+DrainCycles+2. irq_ack is at t+DrainCycles+1. level changes at the edge ending that cycle. write_ra_en is at t+DrainCycles+2. The next irq can be accepted at t+DrainCycles+3.
- Outputs level and depth are registered; irq_ack, write_ra_en and pipe_stall are decodes of the state register (glitch-free, no input paths). mret_err is registered.
- Invariant: stack entries are strictly increasing from bottom to level. depth never exceeds NumLevels-1 and never underflows.

Test Plan:
- Reset then idle, DrainCycles=3: level=0, depth=0, all pulses 0. Assert reset low in mid-DRAIN → outputs return to 0 immediately, no irq_ack.
- irq_valid=1, irq_prio=3 at level 0 → pipe_stall high for 5 cycles; irq_ack on 4th cycle after acceptance; level=3 and depth=1 after it; write_ra_en on 5th cycle only.
- Nest: level 3, irq_prio=5 → level 5, depth 2. mret → level 3, depth 1. mret → level 0, depth 0. Another mret → mret_err=1 one cycle, level stays 0.
- At level 5, irq_prio=5 and irq_prio=2 → no stall, no ack, level stays 5.
- Fill: sequential priorities 1..7 → depth=7. irq_prio=7 at level 7 is ignored. Force full case with NumLevels=4: levels 1, 2, 3 → depth=3, no further accepts.
- Same cycle mret=1 and irq_valid (prio 4) at level 3, depth 1 → pop to level 0 first. Next cycle the irq is accepted; final level=4, depth=1.
